// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: parser states,
// frame constants and a saturating counter helper.
package uart_pkg;

   localparam int FRAME_LEN = 4;
   localparam int TIMER_W = 16;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [$clog2(FRAME_LEN)-1:0] {
      ST_SYNC,
      ST_ADDR,
      ST_DATA,
      ST_CHK
   } parser_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx_ack.sv
// Acknowledge guard for uart_rx consumers: accepts a held-valid byte
// once and answers with a single-cycle registered ready pulse.
module uart_rx_ack (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_data_valid,
   output logic o_accept,
   output logic o_rx_ready
);

   logic r_rx_ready;
   logic r_ack_d;

   // The cycle after an ack uart_rx may still show valid; block it.
   assign o_accept = i_data_valid & ~r_rx_ready & ~r_ack_d;
   assign o_rx_ready = r_rx_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_ready <= 1'b0;
         r_ack_d <= 1'b0;
      end else begin
         r_rx_ready <= o_accept;
         r_ack_d <= r_rx_ready;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser: SYNC, ADDR, DATA, CHK bytes from uart_rx become a
// register-write strobe; bad checksums and timeouts are counted.
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 33320,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic       i_uart_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_byte_in,
   input  logic       i_data_valid,
   output logic       o_rx_ready,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic [7:0] o_err_count,
   output logic       o_busy
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   parser_state_t      r_state;
   logic [TIMER_W-1:0] r_timer;
   logic [7:0]         r_addr;
   logic [7:0]         r_data;
   logic               r_wr_en;
   logic [7:0]         r_wr_addr;
   logic [7:0]         r_wr_data;
   logic [7:0]         r_err_count;
   logic               w_accept;
   logic [7:0]         w_sum;

   uart_rx_ack u_ack (
      .i_clk        (i_uart_clk),
      .i_rst_n      (i_rst_n),
      .i_data_valid (i_data_valid),
      .o_accept     (w_accept),
      .o_rx_ready   (o_rx_ready)
   );

   assign w_sum = r_addr + r_data;

   // An accepted byte takes priority over a timeout in the same cycle.
   always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_SYNC;
         r_timer <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_wr_en <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_err_count <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_accept) begin
            r_timer <= '0;
            unique case (r_state)
               ST_SYNC: begin
                  if (i_byte_in == SYNC_BYTE) r_state <= ST_ADDR;
               end
               ST_ADDR: begin
                  r_addr <= i_byte_in;
                  r_state <= ST_DATA;
               end
               ST_DATA: begin
                  r_data <= i_byte_in;
                  r_state <= ST_CHK;
               end
               ST_CHK: begin
                  r_state <= ST_SYNC;
                  if (i_byte_in == w_sum) begin
                     r_wr_en <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= r_data;
                  end else begin
                     r_err_count <= sat_inc(r_err_count);
                  end
               end
               default: r_state <= ST_SYNC;
            endcase
         end else if (r_state == ST_SYNC) begin
            r_timer <= '0;
         end else if (r_timer == TO_LAST) begin
            r_timer <= '0;
            r_state <= ST_SYNC;
            r_err_count <= sat_inc(r_err_count);
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   assign o_wr_en = r_wr_en;
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;
   assign o_err_count = r_err_count;
   assign o_busy = (r_state != ST_SYNC);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected writes are queued by
// the stimulus, a negedge monitor pops them on every o_wr_en strobe.
module tb_uart_cmd_parser;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       valid = 1'b0;
   logic       rx_ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] err_count;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ready = 0;
   int exp_ready = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;

   uart_cmd_parser #(
      .TIMEOUT_CYCLES (TO),
      .SYNC_BYTE      (8'hA5)
   ) dut (
      .i_uart_clk   (clk),
      .i_rst_n      (rst_n),
      .i_byte_in    (din),
      .i_data_valid (valid),
      .o_rx_ready   (rx_ready),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_err_count  (err_count),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_ready === 1'b1) n_ready++;
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_unexpected: got %h/%h expected none",
                     wr_addr, wr_data);
         end else begin
            exp_w = exp_q.pop_front();
            check("write", {wr_addr, wr_data}, exp_w);
         end
      end
   end

   // Valid held three cycles like uart_rx, then dropped; gap adds idle.
   task automatic send(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1;
      din = b;
      valid = 1'b1;
      exp_ready++;
      repeat (3) @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      send(a, 0);
      send(b, 0);
      send(c, 0);
      send(d, 0);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_wr_en", 16'(wr_en), 16'h0);
      check("reset_addr", 16'(wr_addr), 16'h0);
      check("reset_data", 16'(wr_data), 16'h0);
      check("reset_err", 16'(err_count), 16'h0);
      check("reset_busy", 16'(busy), 16'h0);
      check("reset_ready", 16'(rx_ready), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      exp_q.push_back(16'h1020);
      frame(8'hA5, 8'h10, 8'h20, 8'h30);
      settle();
      check("good_err", 16'(err_count), 16'h0);
      check("good_busy", 16'(busy), 16'h0);
      check("good_ready_cnt", 16'(n_ready), 16'(exp_ready));

      frame(8'hA5, 8'h10, 8'h20, 8'h31);
      settle();
      check("badchk_err", 16'(err_count), 16'h1);
      check("badchk_busy", 16'(busy), 16'h0);

      exp_q.push_back(16'h0102);
      send(8'h00, 0);
      send(8'hFF, 0);
      frame(8'hA5, 8'h01, 8'h02, 8'h03);
      settle();
      check("junk_err", 16'(err_count), 16'h1);
      check("junk_ready_cnt", 16'(n_ready), 16'(exp_ready));

      exp_q.push_back(16'hA501);
      frame(8'hA5, 8'hA5, 8'h01, 8'hA6);
      settle();
      check("sync_as_data_err", 16'(err_count), 16'h1);

      send(8'hA5, 0);
      send(8'h10, 0);
      check("timeout_pending_busy", 16'(busy), 16'h1);
      for (int i = 0; i < 20 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("timeout_busy", 16'(busy), 16'h0);
      check("timeout_err", 16'(err_count), 16'h2);
      exp_q.push_back(16'h0101);
      frame(8'hA5, 8'h01, 8'h01, 8'h02);
      settle();
      check("after_timeout_err", 16'(err_count), 16'h2);

      exp_q.push_back(16'h1020);
      send(8'hA5, 4);
      send(8'h10, 4);
      send(8'h20, 4);
      send(8'h30, 0);
      settle();
      check("byte_wins_err", 16'(err_count), 16'h2);

      send(8'hA5, 0);
      send(8'h10, 5);
      send(8'h20, 0);
      send(8'h30, 0);
      settle();
      check("late_byte_err", 16'(err_count), 16'h3);
      check("late_byte_busy", 16'(busy), 16'h0);

      send(8'hA5, 0);
      send(8'h10, 0);
      check("pre_reset_busy", 16'(busy), 16'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 16'(busy), 16'h0);
      check("midrst_err", 16'(err_count), 16'h0);
      check("midrst_addr", 16'(wr_addr), 16'h0);
      check("midrst_data", 16'(wr_data), 16'h0);
      check("midrst_ready", 16'(rx_ready), 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(16'h3344);
      frame(8'hA5, 8'h33, 8'h44, 8'h77);
      settle();
      check("post_rst_err", 16'(err_count), 16'h0);

      for (int i = 0; i < 254; i++) frame(8'hA5, 8'h01, 8'h01, 8'h00);
      settle();
      check("sat_fe", 16'(err_count), 16'h00FE);
      frame(8'hA5, 8'h01, 8'h01, 8'h00);
      settle();
      check("sat_ff", 16'(err_count), 16'h00FF);
      for (int i = 0; i < 45; i++) frame(8'hA5, 8'h01, 8'h01, 8'h00);
      settle();
      check("sat_hold", 16'(err_count), 16'h00FF);
      check("sat_busy", 16'(busy), 16'h0);

      check("ready_total", 16'(n_ready), 16'(exp_ready));
      check("writes_left", 16'(exp_q.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
